// File: rtl/axi_mem_window_pkg.sv
// axi_mem_window_pkg: response codes and error-responder state types shared by the window bridge
package axi_mem_window_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic {R_IDLE, R_ERR} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
endpackage

// File: rtl/axi_mem_window_err.sv
// axi_mem_window_err: local responder answering out-of-window bursts with DECERR
module axi_mem_window_err #(
    parameter int ID_W = 6
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_ar_take,
    input  logic [ID_W-1:0] i_ar_id,
    input  logic [7:0]      i_ar_len,
    input  logic            i_r_ready,
    input  logic            i_aw_take,
    input  logic [ID_W-1:0] i_aw_id,
    input  logic            i_w_valid,
    input  logic            i_w_last,
    input  logic            i_b_ready,
    output logic            o_rd_idle,
    output logic            o_r_valid,
    output logic            o_r_last,
    output logic [ID_W-1:0] o_r_id,
    output logic            o_wr_idle,
    output logic            o_w_ready,
    output logic            o_b_valid,
    output logic [ID_W-1:0] o_b_id
);
    import axi_mem_window_pkg::*;

    rd_state_e       r_rstate;
    wr_state_e       r_wstate;
    logic [8:0]      r_beats;
    logic [ID_W-1:0] r_rid;
    logic [ID_W-1:0] r_bid;

    // Read error FSM: take the rejected AR, then emit len+1 DECERR beats
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rstate <= R_IDLE;
            r_beats  <= '0;
            r_rid    <= '0;
        end else if (r_rstate == R_IDLE) begin
            if (i_ar_take) begin
                r_rstate <= R_ERR;
                r_rid    <= i_ar_id;
                r_beats  <= 9'(i_ar_len) + 9'd1;
            end
        end else if (i_r_ready) begin
            r_beats <= r_beats - 9'd1;
            if (r_beats == 9'd1)
                r_rstate <= R_IDLE;
        end
    end

    // Write error FSM: swallow the W beats of a rejected burst, then give one DECERR
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wstate <= W_IDLE;
            r_bid    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (i_aw_take) begin
                    r_wstate <= W_DATA;
                    r_bid    <= i_aw_id;
                end
                W_DATA: if (i_w_valid && i_w_last) r_wstate <= W_RESP;
                W_RESP: if (i_b_ready) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign o_rd_idle = (r_rstate == R_IDLE);
    assign o_r_valid = (r_rstate == R_ERR);
    assign o_r_last  = (r_beats == 9'd1);
    assign o_r_id    = r_rid;
    assign o_wr_idle = (r_wstate == W_IDLE);
    assign o_w_ready = (r_wstate == W_DATA);
    assign o_b_valid = (r_wstate == W_RESP);
    assign o_b_id    = r_bid;
endmodule

// File: rtl/axi_mem_window.sv
// axi_mem_window: AXI4 window check, address rebase and outstanding-burst limiter with DECERR responder
module axi_mem_window #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 64,
    parameter int                ID_W     = 6,
    parameter logic [ADDR_W-1:0] WIN_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] DST_BASE = 32'h1000_0000,
    parameter int                MAX_OUT  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_s_ar_valid,
    output logic                o_s_ar_ready,
    input  logic [ADDR_W-1:0]   i_s_ar_addr,
    input  logic [ID_W-1:0]     i_s_ar_id,
    input  logic [7:0]          i_s_ar_len,
    input  logic [2:0]          i_s_ar_size,
    input  logic [1:0]          i_s_ar_burst,
    input  logic [3:0]          i_s_ar_cache,
    input  logic                i_s_ar_lock,
    input  logic [2:0]          i_s_ar_prot,
    input  logic [3:0]          i_s_ar_qos,
    input  logic                i_s_aw_valid,
    output logic                o_s_aw_ready,
    input  logic [ADDR_W-1:0]   i_s_aw_addr,
    input  logic [ID_W-1:0]     i_s_aw_id,
    input  logic [7:0]          i_s_aw_len,
    input  logic [2:0]          i_s_aw_size,
    input  logic [1:0]          i_s_aw_burst,
    input  logic [3:0]          i_s_aw_cache,
    input  logic                i_s_aw_lock,
    input  logic [2:0]          i_s_aw_prot,
    input  logic [3:0]          i_s_aw_qos,
    input  logic                i_s_w_valid,
    output logic                o_s_w_ready,
    input  logic [DATA_W-1:0]   i_s_w_data,
    input  logic [DATA_W/8-1:0] i_s_w_strb,
    input  logic                i_s_w_last,
    output logic                o_s_r_valid,
    input  logic                i_s_r_ready,
    output logic [DATA_W-1:0]   o_s_r_data,
    output logic [ID_W-1:0]     o_s_r_id,
    output logic [1:0]          o_s_r_resp,
    output logic                o_s_r_last,
    output logic                o_s_b_valid,
    input  logic                i_s_b_ready,
    output logic [ID_W-1:0]     o_s_b_id,
    output logic [1:0]          o_s_b_resp,
    output logic                o_m_ar_valid,
    input  logic                i_m_ar_ready,
    output logic [ADDR_W-1:0]   o_m_ar_addr,
    output logic [ID_W-1:0]     o_m_ar_id,
    output logic [7:0]          o_m_ar_len,
    output logic [2:0]          o_m_ar_size,
    output logic [1:0]          o_m_ar_burst,
    output logic [3:0]          o_m_ar_cache,
    output logic                o_m_ar_lock,
    output logic [2:0]          o_m_ar_prot,
    output logic [3:0]          o_m_ar_qos,
    output logic                o_m_aw_valid,
    input  logic                i_m_aw_ready,
    output logic [ADDR_W-1:0]   o_m_aw_addr,
    output logic [ID_W-1:0]     o_m_aw_id,
    output logic [7:0]          o_m_aw_len,
    output logic [2:0]          o_m_aw_size,
    output logic [1:0]          o_m_aw_burst,
    output logic [3:0]          o_m_aw_cache,
    output logic                o_m_aw_lock,
    output logic [2:0]          o_m_aw_prot,
    output logic [3:0]          o_m_aw_qos,
    output logic                o_m_w_valid,
    input  logic                i_m_w_ready,
    output logic [DATA_W-1:0]   o_m_w_data,
    output logic [DATA_W/8-1:0] o_m_w_strb,
    output logic                o_m_w_last,
    input  logic                i_m_r_valid,
    output logic                o_m_r_ready,
    input  logic [DATA_W-1:0]   i_m_r_data,
    input  logic [ID_W-1:0]     i_m_r_id,
    input  logic [1:0]          i_m_r_resp,
    input  logic                i_m_r_last,
    input  logic                i_m_b_valid,
    output logic                o_m_b_ready,
    input  logic [ID_W-1:0]     i_m_b_id,
    input  logic [1:0]          i_m_b_resp
);
    import axi_mem_window_pkg::*;

    localparam int            CW    = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_OUT);

    logic [CW-1:0]     r_rd_out;
    logic [CW-1:0]     r_wr_out;
    logic [CW-1:0]     r_wpend;
    logic [ADDR_W-1:0] w_ar_off;
    logic [ADDR_W-1:0] w_aw_off;
    logic              w_run;
    logic              w_ar_in;
    logic              w_aw_in;
    logic              w_ar_open;
    logic              w_aw_open;
    logic              w_w_open;
    logic              w_ar_take;
    logic              w_aw_take;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_r_done;
    logic              w_w_done;
    logic              w_b_hs;
    logic              w_rd_idle;
    logic              w_wr_idle;
    logic              w_err_r_valid;
    logic              w_err_r_last;
    logic [ID_W-1:0]   w_err_r_id;
    logic              w_err_w_ready;
    logic              w_err_b_valid;
    logic [ID_W-1:0]   w_err_b_id;

    // Every valid/ready is forced low while reset is high, even before state has cleared
    assign w_run = !reset;

    // Window test on the burst start address only; the offset doubles as the rebase term
    assign w_ar_off = i_s_ar_addr - WIN_BASE;
    assign w_aw_off = i_s_aw_addr - WIN_BASE;
    assign w_ar_in  = (i_s_ar_addr >= WIN_BASE) && (w_ar_off < WIN_SIZE);
    assign w_aw_in  = (i_s_aw_addr >= WIN_BASE) && (w_aw_off < WIN_SIZE);

    // A full counter blocks its channel even when a decrement lands in the same cycle
    assign w_ar_open = w_run && w_rd_idle && (r_rd_out < W_MAX);
    assign w_aw_open = w_run && w_wr_idle && (r_wr_out < W_MAX);
    assign w_w_open  = w_run && w_wr_idle && (r_wpend != '0);

    // Rejected bursts are only accepted once all downstream traffic has drained
    assign w_ar_take = w_run && w_rd_idle && i_s_ar_valid && !w_ar_in && (r_rd_out == '0);
    assign w_aw_take = w_run && w_wr_idle && i_s_aw_valid && !w_aw_in && (r_wr_out == '0) && (r_wpend == '0);

    assign o_m_ar_valid = i_s_ar_valid && w_ar_in && w_ar_open;
    assign o_s_ar_ready = (w_ar_in && w_ar_open && i_m_ar_ready) || w_ar_take;
    assign o_m_ar_addr  = w_ar_off + DST_BASE;
    assign o_m_ar_id    = i_s_ar_id;
    assign o_m_ar_len   = i_s_ar_len;
    assign o_m_ar_size  = i_s_ar_size;
    assign o_m_ar_burst = i_s_ar_burst;
    assign o_m_ar_cache = i_s_ar_cache;
    assign o_m_ar_lock  = i_s_ar_lock;
    assign o_m_ar_prot  = i_s_ar_prot;
    assign o_m_ar_qos   = i_s_ar_qos;

    assign o_m_aw_valid = i_s_aw_valid && w_aw_in && w_aw_open;
    assign o_s_aw_ready = (w_aw_in && w_aw_open && i_m_aw_ready) || w_aw_take;
    assign o_m_aw_addr  = w_aw_off + DST_BASE;
    assign o_m_aw_id    = i_s_aw_id;
    assign o_m_aw_len   = i_s_aw_len;
    assign o_m_aw_size  = i_s_aw_size;
    assign o_m_aw_burst = i_s_aw_burst;
    assign o_m_aw_cache = i_s_aw_cache;
    assign o_m_aw_lock  = i_s_aw_lock;
    assign o_m_aw_prot  = i_s_aw_prot;
    assign o_m_aw_qos   = i_s_aw_qos;

    // W only flows downstream behind an already-issued AW
    assign o_m_w_valid = i_s_w_valid && w_w_open;
    assign o_s_w_ready = (w_w_open && i_m_w_ready) || (w_run && w_err_w_ready);
    assign o_m_w_data  = i_s_w_data;
    assign o_m_w_strb  = i_s_w_strb;
    assign o_m_w_last  = i_s_w_last;

    // R/B come from downstream while idle, from the local responder otherwise
    assign o_m_r_ready = w_run && w_rd_idle && i_s_r_ready;
    assign o_s_r_valid = w_run && (w_rd_idle ? i_m_r_valid : w_err_r_valid);
    assign o_s_r_data  = w_rd_idle ? i_m_r_data : '0;
    assign o_s_r_id    = w_rd_idle ? i_m_r_id : w_err_r_id;
    assign o_s_r_resp  = w_rd_idle ? i_m_r_resp : RESP_DECERR;
    assign o_s_r_last  = w_rd_idle ? i_m_r_last : w_err_r_last;

    assign o_m_b_ready = w_run && w_wr_idle && i_s_b_ready;
    assign o_s_b_valid = w_run && (w_wr_idle ? i_m_b_valid : w_err_b_valid);
    assign o_s_b_id    = w_wr_idle ? i_m_b_id : w_err_b_id;
    assign o_s_b_resp  = w_wr_idle ? i_m_b_resp : RESP_DECERR;

    assign w_ar_hs  = o_m_ar_valid && i_m_ar_ready;
    assign w_aw_hs  = o_m_aw_valid && i_m_aw_ready;
    assign w_r_done = i_m_r_valid && o_m_r_ready && i_m_r_last;
    assign w_w_done = o_m_w_valid && i_m_w_ready && i_s_w_last;
    assign w_b_hs   = i_m_b_valid && o_m_b_ready;

    // Outstanding-burst counters; a simultaneous increment and decrement cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_out <= '0;
            r_wr_out <= '0;
            r_wpend  <= '0;
        end else begin
            r_rd_out <= r_rd_out + CW'(w_ar_hs) - CW'(w_r_done);
            r_wr_out <= r_wr_out + CW'(w_aw_hs) - CW'(w_b_hs);
            r_wpend  <= r_wpend + CW'(w_aw_hs) - CW'(w_w_done);
        end
    end

    axi_mem_window_err #(.ID_W(ID_W)) u_err (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_ar_take (w_ar_take),
        .i_ar_id   (i_s_ar_id),
        .i_ar_len  (i_s_ar_len),
        .i_r_ready (i_s_r_ready),
        .i_aw_take (w_aw_take),
        .i_aw_id   (i_s_aw_id),
        .i_w_valid (i_s_w_valid),
        .i_w_last  (i_s_w_last),
        .i_b_ready (i_s_b_ready),
        .o_rd_idle (w_rd_idle),
        .o_r_valid (w_err_r_valid),
        .o_r_last  (w_err_r_last),
        .o_r_id    (w_err_r_id),
        .o_wr_idle (w_wr_idle),
        .o_w_ready (w_err_w_ready),
        .o_b_valid (w_err_b_valid),
        .o_b_id    (w_err_b_id)
    );
endmodule

// File: tb/tb_axi_mem_window.sv
// tb_axi_mem_window: window/rebase vectors, random sweep against a range model, and burst sequences
module tb_axi_mem_window;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_ar_valid, s_ar_ready, s_ar_lock, m_ar_valid, m_ar_ready, m_ar_lock;
    logic [31:0] s_ar_addr, m_ar_addr;
    logic [5:0]  s_ar_id, m_ar_id;
    logic [7:0]  s_ar_len, m_ar_len;
    logic [2:0]  s_ar_size, s_ar_prot, m_ar_size, m_ar_prot;
    logic [1:0]  s_ar_burst, m_ar_burst;
    logic [3:0]  s_ar_cache, s_ar_qos, m_ar_cache, m_ar_qos;
    logic        s_aw_valid, s_aw_ready, s_aw_lock, m_aw_valid, m_aw_ready, m_aw_lock;
    logic [31:0] s_aw_addr, m_aw_addr;
    logic [5:0]  s_aw_id, m_aw_id;
    logic [7:0]  s_aw_len, m_aw_len;
    logic [2:0]  s_aw_size, s_aw_prot, m_aw_size, m_aw_prot;
    logic [1:0]  s_aw_burst, m_aw_burst;
    logic [3:0]  s_aw_cache, s_aw_qos, m_aw_cache, m_aw_qos;
    logic        s_w_valid, s_w_ready, s_w_last, m_w_valid, m_w_ready, m_w_last;
    logic [63:0] s_w_data, m_w_data;
    logic [7:0]  s_w_strb, m_w_strb;
    logic        s_r_valid, s_r_ready, s_r_last, m_r_valid, m_r_ready, m_r_last;
    logic [63:0] s_r_data, m_r_data;
    logic [5:0]  s_r_id, m_r_id;
    logic [1:0]  s_r_resp, m_r_resp;
    logic        s_b_valid, s_b_ready, m_b_valid, m_b_ready;
    logic [5:0]  s_b_id, m_b_id;
    logic [1:0]  s_b_resp, m_b_resp;

    axi_mem_window dut (
        .clock(clk), .reset(rst),
        .i_s_ar_valid(s_ar_valid), .o_s_ar_ready(s_ar_ready), .i_s_ar_addr(s_ar_addr), .i_s_ar_id(s_ar_id),
        .i_s_ar_len(s_ar_len), .i_s_ar_size(s_ar_size), .i_s_ar_burst(s_ar_burst), .i_s_ar_cache(s_ar_cache),
        .i_s_ar_lock(s_ar_lock), .i_s_ar_prot(s_ar_prot), .i_s_ar_qos(s_ar_qos),
        .i_s_aw_valid(s_aw_valid), .o_s_aw_ready(s_aw_ready), .i_s_aw_addr(s_aw_addr), .i_s_aw_id(s_aw_id),
        .i_s_aw_len(s_aw_len), .i_s_aw_size(s_aw_size), .i_s_aw_burst(s_aw_burst), .i_s_aw_cache(s_aw_cache),
        .i_s_aw_lock(s_aw_lock), .i_s_aw_prot(s_aw_prot), .i_s_aw_qos(s_aw_qos),
        .i_s_w_valid(s_w_valid), .o_s_w_ready(s_w_ready), .i_s_w_data(s_w_data), .i_s_w_strb(s_w_strb),
        .i_s_w_last(s_w_last),
        .o_s_r_valid(s_r_valid), .i_s_r_ready(s_r_ready), .o_s_r_data(s_r_data), .o_s_r_id(s_r_id),
        .o_s_r_resp(s_r_resp), .o_s_r_last(s_r_last),
        .o_s_b_valid(s_b_valid), .i_s_b_ready(s_b_ready), .o_s_b_id(s_b_id), .o_s_b_resp(s_b_resp),
        .o_m_ar_valid(m_ar_valid), .i_m_ar_ready(m_ar_ready), .o_m_ar_addr(m_ar_addr), .o_m_ar_id(m_ar_id),
        .o_m_ar_len(m_ar_len), .o_m_ar_size(m_ar_size), .o_m_ar_burst(m_ar_burst), .o_m_ar_cache(m_ar_cache),
        .o_m_ar_lock(m_ar_lock), .o_m_ar_prot(m_ar_prot), .o_m_ar_qos(m_ar_qos),
        .o_m_aw_valid(m_aw_valid), .i_m_aw_ready(m_aw_ready), .o_m_aw_addr(m_aw_addr), .o_m_aw_id(m_aw_id),
        .o_m_aw_len(m_aw_len), .o_m_aw_size(m_aw_size), .o_m_aw_burst(m_aw_burst), .o_m_aw_cache(m_aw_cache),
        .o_m_aw_lock(m_aw_lock), .o_m_aw_prot(m_aw_prot), .o_m_aw_qos(m_aw_qos),
        .o_m_w_valid(m_w_valid), .i_m_w_ready(m_w_ready), .o_m_w_data(m_w_data), .o_m_w_strb(m_w_strb),
        .o_m_w_last(m_w_last),
        .i_m_r_valid(m_r_valid), .o_m_r_ready(m_r_ready), .i_m_r_data(m_r_data), .i_m_r_id(m_r_id),
        .i_m_r_resp(m_r_resp), .i_m_r_last(m_r_last),
        .i_m_b_valid(m_b_valid), .o_m_b_ready(m_b_ready), .i_m_b_id(m_b_id), .i_m_b_resp(m_b_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the window is the address range [0x8000_0000, 0x9000_0000)
    function automatic logic win_in(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8FFF_FFFF);
    endfunction

    // Reference model: window base maps to 0x1000_0000, i.e. a fixed downward shift
    function automatic logic [31:0] rebase(input logic [31:0] a);
        return a - 32'h7000_0000;
    endfunction

    task automatic clear_inputs();
        {s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_ar_lock, s_ar_prot, s_ar_qos} = '0;
        {s_aw_valid, s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst, s_aw_cache, s_aw_lock, s_aw_prot, s_aw_qos} = '0;
        {s_w_valid, s_w_data, s_w_strb, s_w_last, s_r_ready, s_b_ready} = '0;
        {m_ar_ready, m_aw_ready, m_w_ready} = '0;
        {m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last, m_b_valid, m_b_id, m_b_resp} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [9:0] all_hs();
        return {s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid, s_w_ready, m_w_valid,
                s_r_valid, m_r_ready, s_b_valid, m_b_ready};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        in_win;
        logic [31:0] maddr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [30:0] f;
        logic [63:0] d;
        tbl[0] = '{32'h8000_0000, 1'b1, 32'h1000_0000};
        tbl[1] = '{32'h8FFF_FFFF, 1'b1, 32'h1FFF_FFFF};
        tbl[2] = '{32'h9000_0000, 1'b0, 32'h2000_0000};
        tbl[3] = '{32'h7FFF_FFFF, 1'b0, 32'h0FFF_FFFF};
        tbl[4] = '{32'h8000_0040, 1'b1, 32'h1000_0040};
        tbl[5] = '{32'h0000_0000, 1'b0, 32'h9000_0000};
        tbl[6] = '{32'hFFFF_FFFF, 1'b0, 32'h8FFF_FFFF};
        tbl[7] = '{32'h8765_4321, 1'b1, 32'h1765_4321};

        // Reset: all handshake outputs low while reset is high, even with every input active
        rst = 1'b1;
        clear_inputs();
        {s_ar_valid, m_ar_ready, s_aw_valid, m_aw_ready, s_w_valid, m_w_ready} = '1;
        {m_r_valid, s_r_ready, m_b_valid, s_b_ready} = '1;
        s_ar_addr = 32'h8000_0000;
        s_aw_addr = 32'h9000_0000;
        #1;
        chk("reset_handshakes", all_hs(), 10'b0);
        @(negedge clk);
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
        chk("post_reset_idle", all_hs(), 10'b0);

        // Table: window decision and rebase, checked combinationally with no clock edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_ar_valid = 1'b1; s_ar_addr = tbl[i].addr;
            s_aw_valid = 1'b1; s_aw_addr = tbl[i].addr;
            #1;
            chk($sformatf("tbl%0d_ar", i), {m_ar_valid, s_ar_ready, m_ar_addr},
                {tbl[i].in_win, !tbl[i].in_win, tbl[i].maddr});
            chk($sformatf("tbl%0d_aw", i), {m_aw_valid, s_aw_ready, m_aw_addr},
                {tbl[i].in_win, !tbl[i].in_win, tbl[i].maddr});
            #1;
            s_ar_valid = 1'b0; s_aw_valid = 1'b0;
        end

        // Random sweep against the range model, with field pass-through
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'h8000_0000 + $urandom_range(0, 31) - 32'd16;
                2: a = 32'h9000_0000 + $urandom_range(0, 31) - 32'd16;
                default: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
            endcase
            f = 31'($urandom);
            m_ar_ready = 1'($urandom);
            s_ar_valid = 1'b1; s_ar_addr = a;
            {s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_ar_lock, s_ar_prot, s_ar_qos} = f;
            s_aw_valid = 1'b1; s_aw_addr = ~a;
            {s_aw_id, s_aw_len, s_aw_size, s_aw_burst, s_aw_cache, s_aw_lock, s_aw_prot, s_aw_qos} = ~f;
            #1;
            chk("rnd_ar", {m_ar_valid, s_ar_ready, m_ar_addr},
                {win_in(a), win_in(a) ? m_ar_ready : 1'b1, rebase(a)});
            chk("rnd_aw", {m_aw_valid, m_aw_addr}, {win_in(~a), rebase(~a)});
            chk("rnd_fields", {m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_ar_cache, m_ar_lock, m_ar_prot, m_ar_qos,
                               m_aw_id, m_aw_len, m_aw_size, m_aw_burst, m_aw_cache, m_aw_lock, m_aw_prot, m_aw_qos},
                {f, ~f});
            #1;
            clear_inputs();
        end

        // 1: in-window read, 8 beats passed through
        @(negedge clk);
        s_ar_valid = 1'b1; s_ar_addr = 32'h8000_0040; s_ar_len = 8'd7; s_ar_id = 6'd3; m_ar_ready = 1'b1;
        #1;
        chk("t1_ar", {m_ar_valid, s_ar_ready, m_ar_addr, m_ar_id}, {1'b1, 1'b1, 32'h1000_0040, 6'd3});
        step();
        clear_inputs();
        s_r_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            d = {$urandom, $urandom};
            m_r_valid = 1'b1; m_r_id = 6'd3; m_r_data = d; m_r_last = (b == 7);
            #1;
            chk($sformatf("t1_r%0d", b), {s_r_valid, m_r_ready, s_r_id, s_r_resp, s_r_last},
                {1'b1, 1'b1, 6'd3, 2'b00, b == 7});
            chk($sformatf("t1_rdata%0d", b), s_r_data, d);
            step();
        end
        clear_inputs();

        // 2: out-of-window read answered locally with 4 DECERR beats (rd_out back to 0 lets it in at once)
        s_ar_valid = 1'b1; s_ar_addr = 32'h9000_0000; s_ar_len = 8'd3; s_ar_id = 6'd5; m_ar_ready = 1'b1;
        #1;
        chk("t2_take", {m_ar_valid, s_ar_ready}, 2'b01);
        step();
        clear_inputs();
        s_ar_valid = 1'b1; s_ar_addr = 32'h8000_0100; m_ar_ready = 1'b1;
        m_r_valid = 1'b1;
        #1;
        chk("t2_ar_closed", {m_ar_valid, s_ar_ready, m_r_ready}, 3'b000);
        chk("t2_hold", {s_r_valid, s_r_id, s_r_resp, s_r_last}, {1'b1, 6'd5, 2'b11, 1'b0});
        step();
        clear_inputs();
        s_r_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("t2_r%0d", b), {s_r_valid, s_r_id, s_r_resp, s_r_last, s_r_data},
                {1'b1, 6'd5, 2'b11, b == 3, 64'd0});
            step();
        end
        #1;
        chk("t2_done", s_r_valid, 1'b0);

        // 3: out-of-window write, W discarded, single DECERR B
        @(negedge clk);
        clear_inputs();
        s_aw_valid = 1'b1; s_aw_addr = 32'h7FFF_FFF0; s_aw_len = 8'd1; s_aw_id = 6'd2; m_aw_ready = 1'b1;
        #1;
        chk("t3_take", {m_aw_valid, s_aw_ready}, 2'b01);
        step();
        clear_inputs();
        m_w_ready = 1'b1; s_w_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_w_last = (b == 1); s_w_data = {$urandom, $urandom};
            #1;
            chk($sformatf("t3_w%0d", b), {s_w_ready, m_w_valid, s_b_valid}, 3'b100);
            step();
        end
        clear_inputs();
        #1;
        chk("t3_b_hold", {s_b_valid, s_b_id, s_b_resp, s_w_ready}, {1'b1, 6'd2, 2'b11, 1'b0});
        step();
        s_b_ready = 1'b1;
        #1;
        chk("t3_b", {s_b_valid, s_b_id, s_b_resp}, {1'b1, 6'd2, 2'b11});
        step();
        s_b_ready = 1'b0;
        #1;
        chk("t3_done", s_b_valid, 1'b0);

        // 7: W held until its AW, then passed through; B passed through
        @(negedge clk);
        clear_inputs();
        s_w_valid = 1'b1; m_w_ready = 1'b1;
        #1;
        chk("t7_w_blocked", {s_w_ready, m_w_valid}, 2'b00);
        s_aw_valid = 1'b1; s_aw_addr = 32'h8000_1000; s_aw_len = 8'd1; s_aw_id = 6'd9; m_aw_ready = 1'b1;
        #1;
        chk("t7_aw", {m_aw_valid, s_aw_ready, m_aw_addr}, {1'b1, 1'b1, 32'h1000_1000});
        step();
        s_aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom};
            s_w_data = d; s_w_strb = 8'($urandom); s_w_last = (b == 1);
            #1;
            chk($sformatf("t7_w%0d", b), {s_w_ready, m_w_valid, m_w_last, m_w_strb}, {1'b1, 1'b1, b == 1, s_w_strb});
            chk($sformatf("t7_wdata%0d", b), m_w_data, d);
            step();
        end
        s_w_last = 1'b0;
        #1;
        chk("t7_w_after", {s_w_ready, m_w_valid}, 2'b00);
        clear_inputs();
        m_b_valid = 1'b1; m_b_id = 6'd9; s_b_ready = 1'b1;
        #1;
        chk("t7_b", {s_b_valid, m_b_ready, s_b_id, s_b_resp}, {1'b1, 1'b1, 6'd9, 2'b00});
        step();
        clear_inputs();

        // 4: fifth read blocked at MAX_OUT, even across the cycle of the first rlast
        m_ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_ar_valid = 1'b1; s_ar_addr = 32'h8000_0000 + 32'(k * 64); s_ar_id = 6'(k);
            #1;
            chk($sformatf("t4_ar%0d", k), {s_ar_ready, m_ar_valid}, 2'b11);
            step();
        end
        s_ar_addr = 32'h8000_1000;
        #1;
        chk("t4_full", {s_ar_ready, m_ar_valid}, 2'b00);
        step();
        m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
        #1;
        chk("t4_full_dec", {s_ar_ready, m_ar_valid, m_r_ready}, 3'b001);
        step();
        m_r_valid = 1'b0;
        #1;
        chk("t4_reopen", {s_ar_ready, m_ar_valid}, 2'b11);
        step();
        s_ar_valid = 1'b0;
        m_r_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        clear_inputs();

        // 5: out-of-window read waits for both outstanding reads to drain
        m_ar_ready = 1'b1; s_ar_valid = 1'b1; s_ar_addr = 32'h8000_2000;
        step();
        step();
        m_ar_ready = 1'b0;
        s_ar_addr = 32'hA000_0000; s_ar_len = 8'd1; s_ar_id = 6'd7;
        #1;
        chk("t5_held0", {s_ar_ready, m_ar_valid}, 2'b00);
        step();
        m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
        #1;
        chk("t5_held1", {s_ar_ready, s_r_resp}, {1'b0, 2'b00});
        step();
        #1;
        chk("t5_held2", s_ar_ready, 1'b0);
        step();
        m_r_valid = 1'b0;
        #1;
        chk("t5_take", {s_ar_ready, s_r_valid}, 2'b10);
        step();
        s_ar_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            chk($sformatf("t5_r%0d", b), {s_r_valid, s_r_id, s_r_resp, s_r_last}, {1'b1, 6'd7, 2'b11, b == 1});
            step();
        end
        #1;
        chk("t5_done", s_r_valid, 1'b0);

        // 6: reset in W_DATA after 1 of 4 beats abandons the burst
        @(negedge clk);
        clear_inputs();
        s_aw_valid = 1'b1; s_aw_addr = 32'h0000_1000; s_aw_len = 8'd3; s_aw_id = 6'd4;
        step();
        s_aw_valid = 1'b0; s_w_valid = 1'b1;
        #1;
        chk("t6_wdata", s_w_ready, 1'b1);
        step();
        rst = 1'b1;
        {s_ar_valid, m_ar_ready, s_aw_valid, m_aw_ready, s_w_valid, m_w_ready} = '1;
        {m_r_valid, s_r_ready, m_b_valid, s_b_ready} = '1;
        s_ar_addr = 32'h8000_3000;
        #1;
        chk("t6_in_reset", all_hs(), 10'b0);
        step();
        rst = 1'b0;
        clear_inputs();
        s_ar_valid = 1'b1; s_ar_addr = 32'h8000_3000;
        s_aw_valid = 1'b1; s_aw_addr = 32'hC000_0000;
        s_w_valid = 1'b1; m_w_ready = 1'b1;
        #1;
        chk("t6_after", {m_ar_valid, s_aw_ready, m_aw_valid, s_w_ready, m_w_valid, s_r_valid, s_b_valid},
            7'b1100000);
        #1;
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
